// File: rtl/nonce_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : nonce_dispatcher
// Purpose  : Round-robin nonce issue to NCORE hashing cores, with golden-nonce
//            latch. Optional macro NONCE_DEBUG_OFFSET_EN adds a fixed offset
//            to the issued nonce.
// Revision : 1.0 - initial release
// ============================================================================
module nonce_dispatcher #(
  parameter int          NCORE       = 4,
  parameter logic [31:0] NONCE_START = 32'd0,
  parameter logic [31:0] NONCE_LAST  = 32'hFFFFFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NCORE-1:0]      req,
  output logic [NCORE-1:0]      gnt,
  output logic [31:0]           nonce_out,
  input  logic [NCORE-1:0]      found,
  input  logic [32*NCORE-1:0]   found_nonce_in,
  output logic                  hit_valid,
  output logic [31:0]           hit_nonce,
  output logic [3:0]            hit_core,
  output logic                  busy,
  output logic                  exhausted
);

  localparam int c_idxw = (NCORE > 1) ? $clog2(NCORE) : 1;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;
  localparam logic [1:0] c_st_exh  = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [NCORE-1:0]  r_gnt;
  logic [NCORE-1:0]  w_gnt_next;
  logic [31:0]       r_nonce_out;
  logic [31:0]       r_next_nonce;
  logic [31:0]       w_issue_nonce;
  logic [c_idxw-1:0] r_rr_ptr;
  logic [c_idxw-1:0] w_win_idx;
  logic              w_any_req;
  logic              w_grant;
  logic              w_restart;
  logic              w_any_found;
  logic [3:0]        w_hit_idx;
  logic [31:0]       w_hit_nonce;
  logic              r_hit_valid;
  logic [31:0]       r_hit_nonce;
  logic [3:0]        r_hit_core;

  // Round-robin search: first requester at or after r_rr_ptr wins.
  always_comb begin
    logic [c_idxw-1:0] v_cand;
    v_cand    = '0;
    w_any_req = 1'b0;
    w_win_idx = '0;
    for (int i = 0; i < NCORE; i++) begin
      v_cand = c_idxw'((int'(r_rr_ptr) + i) % NCORE);
      if (!w_any_req && req[v_cand]) begin
        w_any_req = 1'b1;
        w_win_idx = v_cand;
      end
    end
  end

  // Descending scan so the lowest-index reporter is the last one written.
  always_comb begin
    w_hit_idx   = 4'd0;
    w_hit_nonce = 32'd0;
    for (int i = NCORE - 1; i >= 0; i--) begin
      if (found[i]) begin
        w_hit_idx   = 4'(i);
        w_hit_nonce = found_nonce_in[i*32 +: 32];
      end
    end
  end

  assign w_any_found = |found;
  assign w_grant     = (r_state == c_st_run) && w_any_req;
  assign w_restart   = start && !abort && (r_state != c_st_run);

  always_comb begin
    w_gnt_next = '0;
    if (w_grant) begin
      w_gnt_next[w_win_idx] = 1'b1;
    end
  end

`ifdef NONCE_DEBUG_OFFSET_EN
  assign w_issue_nonce = r_next_nonce + 32'd411342200;
`else
  assign w_issue_nonce = r_next_nonce;
`endif

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state. Abort dominates; a hit dominates exhaustion.
  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = c_st_idle;
    end else begin
      case (r_state)
        c_st_run: begin
          if (w_any_found) begin
            w_state_next = c_st_done;
          end else if (w_grant && (r_next_nonce == NONCE_LAST)) begin
            w_state_next = c_st_exh;
          end
        end
        default: begin
          if (start) begin
            w_state_next = c_st_run;
          end
        end
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    busy      = (r_state == c_st_run);
    exhausted = (r_state == c_st_exh);
  end

  // Dispatch datapath; the nonce counter saturates at NONCE_LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt        <= '0;
      r_nonce_out  <= 32'd0;
      r_next_nonce <= NONCE_START;
      r_rr_ptr     <= '0;
    end else begin
      r_gnt <= w_gnt_next;
      if (w_grant) begin
        r_nonce_out <= w_issue_nonce;
        r_rr_ptr    <= (w_win_idx == c_idxw'(NCORE - 1)) ? '0 : w_win_idx + 1'b1;
        if (r_next_nonce != NONCE_LAST) begin
          r_next_nonce <= r_next_nonce + 32'd1;
        end
      end else if (w_restart) begin
        r_next_nonce <= NONCE_START;
        r_rr_ptr     <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_valid <= 1'b0;
      r_hit_nonce <= 32'd0;
      r_hit_core  <= 4'd0;
    end else if (w_restart) begin
      r_hit_valid <= 1'b0;
      r_hit_nonce <= 32'd0;
      r_hit_core  <= 4'd0;
    end else if ((r_state == c_st_run) && w_any_found && !abort) begin
      r_hit_valid <= 1'b1;
      r_hit_nonce <= w_hit_nonce;
      r_hit_core  <= w_hit_idx;
    end
  end

  assign gnt       = r_gnt;
  assign nonce_out = r_nonce_out;
  assign hit_valid = r_hit_valid;
  assign hit_nonce = r_hit_nonce;
  assign hit_core  = r_hit_core;

endmodule
`default_nettype wire

// File: tb/tb_nonce_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_nonce_dispatcher
// Purpose  : Self-checking bench for nonce_dispatcher (default range instance
//            plus a near-top-of-range instance for exhaustion).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nonce_dispatcher;

`ifdef NONCE_DEBUG_OFFSET_EN
  localparam logic [31:0] c_off = 32'd411342200;
`else
  localparam logic [31:0] c_off = 32'd0;
`endif

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [31:0] nonce;
  } vec_t;

  typedef struct {
    logic [3:0]  gnt;
    logic [31:0] nonce;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start, abort;
  logic [3:0]   req, found, gnt;
  logic [127:0] fni;
  logic [31:0]  nonce_out, hit_nonce;
  logic         hit_valid, busy, exhausted;
  logic [3:0]   hit_core;

  logic         xstart, xabort;
  logic [3:0]   xreq, xfound, xgnt;
  logic [127:0] xfni;
  logic [31:0]  xnonce_out, xhit_nonce;
  logic         xhit_valid, xbusy, xexhausted;
  logic [3:0]   xhit_core;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs [11];
  exp_t sbq [$];
  exp_t e;

  nonce_dispatcher #(.NCORE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .req(req), .gnt(gnt),
    .nonce_out(nonce_out), .found(found), .found_nonce_in(fni),
    .hit_valid(hit_valid), .hit_nonce(hit_nonce), .hit_core(hit_core),
    .busy(busy), .exhausted(exhausted)
  );

  nonce_dispatcher #(.NCORE(4), .NONCE_START(32'hFFFFFFFD), .NONCE_LAST(32'hFFFFFFFF)) dut_x (
    .clk(clk), .rst(rst), .start(xstart), .abort(xabort), .req(xreq), .gnt(xgnt),
    .nonce_out(xnonce_out), .found(xfound), .found_nonce_in(xfni),
    .hit_valid(xhit_valid), .hit_nonce(xhit_nonce), .hit_core(xhit_core),
    .busy(xbusy), .exhausted(xexhausted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    // req pattern applied for one cycle, and the grant expected after the edge
    vecs[0]  = '{4'b1111, 4'b0001, 32'd0};
    vecs[1]  = '{4'b1110, 4'b0010, 32'd1};
    vecs[2]  = '{4'b1101, 4'b0100, 32'd2};
    vecs[3]  = '{4'b1011, 4'b1000, 32'd3};
    vecs[4]  = '{4'b0111, 4'b0001, 32'd4};
    vecs[5]  = '{4'b0000, 4'b0000, 32'd0};
    vecs[6]  = '{4'b0100, 4'b0100, 32'd5};
    vecs[7]  = '{4'b0000, 4'b0000, 32'd0};
    vecs[8]  = '{4'b1001, 4'b1000, 32'd6};
    vecs[9]  = '{4'b0001, 4'b0001, 32'd7};
    vecs[10] = '{4'b0000, 4'b0000, 32'd0};

    rst = 1'b1; start = 0; abort = 0; req = 0; found = 0; fni = '0;
    xstart = 0; xabort = 0; xreq = 0; xfound = 0; xfni = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_nonce", nonce_out, 32'd0);
    chk("rst_hit_valid", {31'd0, hit_valid}, 32'd0);
    chk("rst_hit_nonce", hit_nonce, 32'd0);
    chk("rst_hit_core", {28'd0, hit_core}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_exhausted", {31'd0, exhausted}, 32'd0);
    chk("rst_x_gnt", {28'd0, xgnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", {31'd0, busy}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      req = vecs[i].req;
      sbq.push_back('{vecs[i].gnt, vecs[i].nonce + c_off});
      @(negedge clk);
      e = sbq.pop_front();
      chk($sformatf("vec%0d_gnt", i), {28'd0, gnt}, {28'd0, e.gnt});
      if (e.gnt != 4'd0) chk($sformatf("vec%0d_nonce", i), nonce_out, e.nonce);
    end
    req = 4'b0000;

    // two simultaneous reporters: core 2 must win over core 3
    fni   = {32'hDEADBEEF, 32'h1A2B3C4D, 32'h0, 32'h0};
    found = 4'b1100;
    @(negedge clk);
    found = 4'b0000;
    chk("hit_busy", {31'd0, busy}, 32'd0);
    chk("hit_valid", {31'd0, hit_valid}, 32'd1);
    chk("hit_nonce", hit_nonce, 32'h1A2B3C4D);
    chk("hit_core", {28'd0, hit_core}, 32'd2);

    req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("done_no_gnt", {28'd0, gnt}, 32'd0);
    end
    req = 4'b0000;
    fni   = {96'd0, 32'h12345678};
    found = 4'b0001;
    @(negedge clk);
    found = 4'b0000;
    chk("done_found_ignored_nonce", hit_nonce, 32'h1A2B3C4D);
    chk("done_found_ignored_core", {28'd0, hit_core}, 32'd2);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", {31'd0, busy}, 32'd1);
    chk("restart_hit_clr", {31'd0, hit_valid}, 32'd0);
    req = 4'b0010;
    sbq.push_back('{4'b0010, 32'd0 + c_off});
    @(negedge clk);
    req = 4'b0000;
    e = sbq.pop_front();
    chk("restart_gnt", {28'd0, gnt}, {28'd0, e.gnt});
    chk("restart_nonce", nonce_out, e.nonce);

    // abort with a hit and a grant in the same cycle
    abort = 1'b1; found = 4'b0010; req = 4'b0001;
    sbq.push_back('{4'b0001, 32'd1 + c_off});
    @(negedge clk);
    abort = 1'b0; found = 4'b0000; req = 4'b0000;
    e = sbq.pop_front();
    chk("abort_gnt", {28'd0, gnt}, {28'd0, e.gnt});
    chk("abort_nonce", nonce_out, e.nonce);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hit_valid", {31'd0, hit_valid}, 32'd0);

    // asynchronous reset while a grant is on the outputs
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    chk("pre_rst_gnt", {28'd0, gnt}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_gnt", {28'd0, gnt}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_nonce", nonce_out, 32'd0);
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_gnt", {28'd0, gnt}, 32'd0);

    // exhaustion near the top of the nonce space
    xstart = 1'b1;
    @(negedge clk);
    xstart = 1'b0;
    xreq = 4'b1111;
    sbq.push_back('{4'b0001, 32'hFFFFFFFD + c_off});
    sbq.push_back('{4'b0010, 32'hFFFFFFFE + c_off});
    sbq.push_back('{4'b0100, 32'hFFFFFFFF + c_off});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = sbq.pop_front();
      chk($sformatf("exh%0d_gnt", i), {28'd0, xgnt}, {28'd0, e.gnt});
      chk($sformatf("exh%0d_nonce", i), xnonce_out, e.nonce);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("exh_no_gnt", {28'd0, xgnt}, 32'd0);
      chk("exh_flag", {31'd0, xexhausted}, 32'd1);
      chk("exh_busy", {31'd0, xbusy}, 32'd0);
    end
    xfound = 4'b0001;
    @(negedge clk);
    xfound = 4'b0000;
    chk("exh_found_ignored", {31'd0, xhit_valid}, 32'd0);

    xstart = 1'b1;
    @(negedge clk);
    xstart = 1'b0;
    chk("exh_restart_flag", {31'd0, xexhausted}, 32'd0);
    chk("exh_restart_busy", {31'd0, xbusy}, 32'd1);
    @(negedge clk);
    chk("exh_restart_gnt", {28'd0, xgnt}, 32'd1);
    chk("exh_restart_nonce", xnonce_out, 32'hFFFFFFFD + c_off);
    @(negedge clk);
    chk("exh_restart_gnt2", {28'd0, xgnt}, 32'd2);
    // hit in the same cycle as the final grant: DONE wins over EXHAUSTED
    xfni   = {32'h0, 32'hCAFEF00D, 64'd0};
    xfound = 4'b0100;
    @(negedge clk);
    xfound = 4'b0000;
    xreq   = 4'b0000;
    chk("final_gnt", {28'd0, xgnt}, 32'd4);
    chk("final_nonce", xnonce_out, 32'hFFFFFFFF + c_off);
    chk("final_hit_valid", {31'd0, xhit_valid}, 32'd1);
    chk("final_hit_nonce", xhit_nonce, 32'hCAFEF00D);
    chk("final_hit_core", {28'd0, xhit_core}, 32'd2);
    chk("final_not_exh", {31'd0, xexhausted}, 32'd0);
    chk("final_not_busy", {31'd0, xbusy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
